// File: rtl/l1_data_cache.sv
// rtl/l1_data_cache.sv - set-associative write-back, write-allocate L1 data cache with true-LRU replacement
module l1_data_cache #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_WAYS   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                cpu_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_data_in,
    input  logic                                 cpu_read,
    input  logic                                 cpu_write,
    output logic [DATA_WIDTH-1:0]                cpu_data_out,
    output logic                                 cpu_ready,
    output logic                                 l1_hit,
    output logic [ADDR_WIDTH-1:0]                l2_cache_addr,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
    output logic                                 l2_cache_read,
    output logic                                 l2_cache_write,
    input  logic                                 l2_cache_ready,
    input  logic                                 l2_cache_hit
);
    localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_W    = $clog2(BLOCK_SIZE);
    localparam int IDX_W    = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W   = BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND} state_t;

    state_t              state_q;
    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty [NUM_SETS];
    logic [TAG_W-1:0]    tags  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    lru_q [NUM_SETS][NUM_WAYS];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_write_q;
    logic                  missed_q;
    logic [WAY_W-1:0]      victim_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             hit;
    logic             found_inv;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] best_age;
    logic             unused_l2_hit;

    assign req_tag       = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx       = addr_q[OFF_W +: IDX_W];
    assign req_off       = addr_q[OFF_W-1:0];
    assign unused_l2_hit = l2_cache_hit;

    // Age 0 is most recent; victim is the lowest invalid way, else the oldest way.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_inv  = 1'b0;
        victim_way = '0;
        best_age   = lru_q[req_idx][0];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid[req_idx][w] && !found_inv) begin
                found_inv  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 1; w < NUM_WAYS; w++) begin
                if (lru_q[req_idx][w] > best_age) begin
                    best_age   = lru_q[req_idx][w];
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            is_write_q        <= 1'b0;
            missed_q          <= 1'b0;
            victim_q          <= '0;
            cpu_data_out      <= '0;
            cpu_ready         <= 1'b0;
            l1_hit            <= 1'b0;
            l2_cache_addr     <= '0;
            l2_cache_data_out <= '0;
            l2_cache_read     <= 1'b0;
            l2_cache_write    <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    lru_q[s][w] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        addr_q     <= cpu_addr;
                        wdata_q    <= cpu_data_in;
                        is_write_q <= cpu_write;
                        missed_q   <= 1'b0;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (is_write_q) begin
                            dirty[req_idx][hit_way] <= 1'b1;
                            cpu_data_out            <= wdata_q;
                        end else begin
                            cpu_data_out <= data[req_idx][hit_way][int'(req_off)*DATA_WIDTH +: DATA_WIDTH];
                        end
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                lru_q[req_idx][w] <= '0;
                            end else if (lru_q[req_idx][w] <= lru_q[req_idx][hit_way] &&
                                         lru_q[req_idx][w] != WAY_W'(NUM_WAYS-1)) begin
                                lru_q[req_idx][w] <= lru_q[req_idx][w] + 1'b1;
                            end
                        end
                        cpu_ready <= 1'b1;
                        l1_hit    <= !missed_q;
                        state_q   <= RESPOND;
                    end else begin
                        missed_q <= 1'b1;
                        victim_q <= victim_way;
                        if (valid[req_idx][victim_way] && dirty[req_idx][victim_way]) begin
                            l2_cache_write    <= 1'b1;
                            l2_cache_addr     <= {tags[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
                            l2_cache_data_out <= data[req_idx][victim_way];
                            state_q           <= WRITEBACK;
                        end else begin
                            l2_cache_read <= 1'b1;
                            l2_cache_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state_q       <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (l2_cache_ready) begin
                        l2_cache_write           <= 1'b0;
                        dirty[req_idx][victim_q] <= 1'b0;
                        l2_cache_read            <= 1'b1;
                        l2_cache_addr            <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state_q                  <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (l2_cache_ready) begin
                        l2_cache_read            <= 1'b0;
                        valid[req_idx][victim_q] <= 1'b1;
                        dirty[req_idx][victim_q] <= 1'b0;
                        state_q                  <= LOOKUP;
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    l1_hit    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && is_write_q) begin
            data[req_idx][hit_way][int'(req_off)*DATA_WIDTH +: DATA_WIDTH] <= wdata_q;
        end
        if (state_q == ALLOCATE && l2_cache_ready) begin
            data[req_idx][victim_q] <= l2_cache_data_in;
            tags[req_idx][victim_q] <= req_tag;
        end
    end
endmodule

// File: tb/tb_l1_data_cache.sv
// tb/tb_l1_data_cache.sv - self-checking bench for l1_data_cache against a recency-list cache model
module tb_l1_data_cache;
    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [127:0] line;
    } l2_ev_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [10:0]          cpu_addr;
    logic [7:0]           cpu_data_in;
    logic                 cpu_read;
    logic                 cpu_write;
    logic [7:0]           cpu_data_out;
    logic                 cpu_ready;
    logic                 l1_hit;
    logic [10:0]          l2_cache_addr;
    logic [15:0][7:0]     l2_cache_data_out;
    logic [15:0][7:0]     l2_cache_data_in = '0;
    logic                 l2_cache_read;
    logic                 l2_cache_write;
    logic                 l2_cache_ready = 1'b0;
    logic                 l2_cache_hit = 1'b0;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     l2_cnt = 0;
    l2_ev_t resp_ev;
    l2_ev_t obs_q[$];
    l2_ev_t exp_q[$];
    logic [7:0] l2_mem   [2048];
    logic [7:0] ref_arch [2048];
    logic [7:0] ref_l2   [2048];
    logic [3:0] mq_tag   [8][$];
    bit         mq_dirty [8][$];
    logic [10:0] last_addr;

    always #5 clk = ~clk;

    l1_data_cache dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out),
        .cpu_ready(cpu_ready), .l1_hit(l1_hit), .l2_cache_addr(l2_cache_addr),
        .l2_cache_data_out(l2_cache_data_out), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_read(l2_cache_read), .l2_cache_write(l2_cache_write),
        .l2_cache_ready(l2_cache_ready), .l2_cache_hit(l2_cache_hit)
    );

    // Next level: ready on the third cycle of a held strobe, one cycle wide.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (l2_cache_read && l2_cache_write) begin
                n_fail++;
                $display("FAIL l2_strobe_overlap t=%0t read=%b write=%b required not both", $time, l2_cache_read, l2_cache_write);
            end
        end
        if (!rst_n) begin
            l2_cnt = 0;
            l2_cache_ready = 1'b0;
        end else if (l2_cache_ready) begin
            l2_cache_ready = 1'b0;
            l2_cnt = 0;
        end else if (l2_cache_read || l2_cache_write) begin
            l2_cnt++;
            if (l2_cnt == 3) begin
                l2_cache_ready = 1'b1;
                resp_ev.wr   = l2_cache_write;
                resp_ev.addr = l2_cache_addr;
                if (l2_cache_write) begin
                    resp_ev.line = l2_cache_data_out;
                    for (int k = 0; k < 16; k++) l2_mem[int'(l2_cache_addr) + k] = l2_cache_data_out[k];
                end else begin
                    resp_ev.line = '0;
                    for (int k = 0; k < 16; k++) l2_cache_data_in[k] = l2_mem[int'(l2_cache_addr) + k];
                end
                obs_q.push_back(resp_ev);
            end
        end
    end

    // Reference: each set is a recency-ordered tag list (front = most recent), two entries deep.
    task automatic model_access(input bit wr, input logic [10:0] a, input logic [7:0] d,
                                output logic [7:0] ed, output logic eh);
        logic [2:0] s = a[6:4];
        logic [3:0] t = a[10:7];
        logic [3:0] vt;
        int         pos = -1;
        int         base;
        bit         dt;
        l2_ev_t     ev;
        exp_q.delete();
        for (int i = 0; i < mq_tag[s].size(); i++) if (mq_tag[s][i] == t) pos = i;
        if (pos >= 0) begin
            eh = 1'b1;
            dt = mq_dirty[s][pos];
            mq_tag[s].delete(pos);
            mq_dirty[s].delete(pos);
        end else begin
            eh = 1'b0;
            dt = 1'b0;
            if (mq_tag[s].size() == 2) begin
                vt = mq_tag[s][1];
                if (mq_dirty[s][1]) begin
                    base    = int'({vt, s, 4'b0000});
                    ev.wr   = 1'b1;
                    ev.addr = 11'(base);
                    for (int k = 0; k < 16; k++) begin
                        ev.line[k*8 +: 8] = ref_arch[base + k];
                        ref_l2[base + k]  = ref_arch[base + k];
                    end
                    exp_q.push_back(ev);
                end
                void'(mq_tag[s].pop_back());
                void'(mq_dirty[s].pop_back());
            end
            ev.wr   = 1'b0;
            ev.addr = {t, s, 4'b0000};
            ev.line = '0;
            exp_q.push_back(ev);
        end
        mq_tag[s].push_front(t);
        mq_dirty[s].push_front(dt | wr);
        if (wr) ref_arch[a] = d;
        ed = ref_arch[a];
    endtask

    task automatic do_access(input bit wr, input logic [10:0] a, input logic [7:0] d,
                             output logic [7:0] gd, output logic gh, output int lat,
                             output bit to, output logic rdy_after);
        obs_q.delete();
        @(negedge clk);
        cpu_addr = a; cpu_data_in = d; cpu_write = wr; cpu_read = ~wr;
        @(posedge clk);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        lat = 0; to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) begin to = 1'b0; break; end
        end
        gd = cpu_data_out;
        gh = l1_hit;
        @(negedge clk);
        rdy_after = cpu_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cpu_ready, l1_hit, l2_cache_read, l2_cache_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got ready=%b hit=%b rd=%b wr=%b required all 0", cpu_ready, l1_hit, l2_cache_read, l2_cache_write);
        end
        n_cmp++;
        if (cpu_data_out !== 8'h00 || l2_cache_addr !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_data got data_out=%h l2_addr=%h required 00/000", cpu_data_out, l2_cache_addr);
        end
        n_cmp++;
        if (l2_cache_data_out !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_line got %h required 0", l2_cache_data_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        logic [7:0] ed, gd; logic eh, gh, ra; int lat; bit to;
        model_access(1'b0, 11'h000, 8'h00, ed, eh);
        do_access(1'b0, 11'h000, 8'h00, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gd !== 8'h00 || gh !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read got data=%h hit=%b timeout=%b required data=00 hit=0", gd, gh, to);
        end
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0].wr !== 1'b0 || obs_q[0].addr !== 11'h000) begin
            n_fail++;
            $display("FAIL first_read_l2 got %0d events required one read at 000", obs_q.size());
        end
        n_cmp++;
        if (ra !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_pulse_width got ready=%b one cycle later required 0", ra);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] ed, gd; logic eh, gh, ra; int lat; bit to, ev_bad; int n_reads = 0;
        for (int a = 1; a <= 'h63; a++) begin
            model_access(1'b0, 11'(a), 8'h00, ed, eh);
            do_access(1'b0, 11'(a), 8'h00, gd, gh, lat, to, ra);
            n_reads += obs_q.size();
            n_cmp++;
            if (to || gd !== ed || gh !== eh) begin
                n_fail++;
                $display("FAIL seq_read addr=%h got data=%h hit=%b timeout=%b required data=%h hit=%b", a, gd, gh, to, ed, eh);
            end
            ev_bad = (obs_q.size() != exp_q.size());
            for (int i = 0; i < obs_q.size() && !ev_bad; i++) if (obs_q[i] !== exp_q[i]) ev_bad = 1'b1;
            n_cmp++;
            if (ev_bad) begin
                n_fail++;
                $display("FAIL seq_l2 addr=%h got %0d events required %0d", a, obs_q.size(), exp_q.size());
            end
        end
        n_cmp++;
        if (n_reads != 6) begin
            n_fail++;
            $display("FAIL seq_l2_count got %0d fills after 000 required 6", n_reads);
        end
    endtask

    task automatic test_write_hit();
        logic [7:0] ed, gd; logic eh, gh, ra; int lat; bit to;
        model_access(1'b1, 11'h003, 8'h5A, ed, eh);
        do_access(1'b1, 11'h003, 8'h5A, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gd !== 8'h5A || gh !== 1'b1 || lat != 2 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_hit got data=%h hit=%b lat=%0d l2=%0d required 5A/1/2/0", gd, gh, lat, obs_q.size());
        end
        model_access(1'b0, 11'h003, 8'h00, ed, eh);
        do_access(1'b0, 11'h003, 8'h00, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gd !== 8'h5A || gh !== 1'b1 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL read_after_write got data=%h hit=%b l2=%0d required 5A/1/0", gd, gh, obs_q.size());
        end
    endtask

    task automatic test_writeback();
        logic [7:0] ed, gd; logic eh, gh, ra; int lat; bit to; logic [127:0] exp_line;
        for (int k = 0; k < 16; k++) exp_line[k*8 +: 8] = 8'(k);
        exp_line[7:0]   = 8'hA5;
        exp_line[31:24] = 8'h5A;
        model_access(1'b1, 11'h000, 8'hA5, ed, eh);
        do_access(1'b1, 11'h000, 8'hA5, gd, gh, lat, to, ra);
        model_access(1'b0, 11'h080, 8'h00, ed, eh);
        do_access(1'b0, 11'h080, 8'h00, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gd !== 8'h80 || gh !== 1'b0 || obs_q.size() != 1 || obs_q[0].wr !== 1'b0 || obs_q[0].addr !== 11'h080) begin
            n_fail++;
            $display("FAIL fill_way1 got data=%h hit=%b l2=%0d required 80/0 one read at 080", gd, gh, obs_q.size());
        end
        model_access(1'b0, 11'h100, 8'h00, ed, eh);
        do_access(1'b0, 11'h100, 8'h00, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gd !== 8'h00 || gh !== 1'b0) begin
            n_fail++;
            $display("FAIL evict_read got data=%h hit=%b required 00/0", gd, gh);
        end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0].wr !== 1'b1 || obs_q[0].addr !== 11'h000 || obs_q[0].line !== exp_line ||
            obs_q[1].wr !== 1'b0 || obs_q[1].addr !== 11'h100) begin
            n_fail++;
            $display("FAIL writeback_seq got %0d events line=%h required write 000 line=%h then read 100",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].line : 128'h0, exp_line);
        end
    endtask

    task automatic test_random();
        logic [7:0] ed, gd, d; logic eh, gh, ra; int lat; bit to, wr, ev_bad; logic [10:0] a;
        for (int n = 0; n < 80; n++) begin
            a  = {4'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            model_access(wr, a, d, ed, eh);
            do_access(wr, a, d, gd, gh, lat, to, ra);
            last_addr = a;
            n_cmp++;
            if (to || gd !== ed || gh !== eh || (eh && lat != 2)) begin
                n_fail++;
                $display("FAIL rand_access wr=%b addr=%h got data=%h hit=%b lat=%0d required data=%h hit=%b", wr, a, gd, gh, lat, ed, eh);
            end
            ev_bad = (obs_q.size() != exp_q.size());
            for (int i = 0; i < obs_q.size() && !ev_bad; i++) if (obs_q[i] !== exp_q[i]) ev_bad = 1'b1;
            n_cmp++;
            if (ev_bad) begin
                n_fail++;
                $display("FAIL rand_l2 addr=%h got %0d events (first %h) required %0d events (first %h)", a,
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0].addr : 11'h7ff,
                         exp_q.size(), (exp_q.size() > 0) ? exp_q[0].addr : 11'h7ff);
            end
        end
    endtask

    // A strobe held high is re-sampled only in IDLE, so six edges give two hit completions.
    task automatic test_back_to_back();
        logic [7:0] ed; logic eh; int pulses = 0, hits = 0, bad_data = 0;
        model_access(1'b0, last_addr, 8'h00, ed, eh);
        model_access(1'b0, last_addr, 8'h00, ed, eh);
        obs_q.delete();
        @(negedge clk);
        cpu_addr = last_addr; cpu_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                pulses++;
                if (l1_hit) hits++;
                if (cpu_data_out !== ed) bad_data++;
            end
        end
        cpu_read = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pulses != 2 || hits != 2 || bad_data != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back got pulses=%0d hits=%0d bad_data=%0d l2=%0d required 2/2/0/0", pulses, hits, bad_data, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_alloc();
        logic [7:0] ed, gd; logic eh, gh, ra; int lat; bit to, seen = 1'b0;
        @(negedge clk);
        cpu_addr = 11'h7F0; cpu_read = 1'b1;
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l2_cache_read) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL alloc_start got no l2 read within 20 cycles required one");
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (l2_cache_read !== 1'b0 || l2_cache_write !== 1'b0 || cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got rd=%b wr=%b ready=%b required 0/0/0", l2_cache_read, l2_cache_write, cpu_ready);
        end
        for (int s = 0; s < 8; s++) begin
            n_cmp++;
            if (dut.valid[s] !== 2'b00 || dut.dirty[s] !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_valid set=%0d got valid=%b dirty=%b required 00/00", s, dut.valid[s], dut.dirty[s]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            mq_tag[s].delete();
            mq_dirty[s].delete();
        end
        for (int i = 0; i < 2048; i++) ref_arch[i] = ref_l2[i];
        model_access(1'b0, 11'h000, 8'h00, ed, eh);
        do_access(1'b0, 11'h000, 8'h00, gd, gh, lat, to, ra);
        n_cmp++;
        if (to || gh !== 1'b0 || gd !== ed || obs_q.size() != 1 || obs_q[0].addr !== 11'h000) begin
            n_fail++;
            $display("FAIL post_reset_read got data=%h hit=%b l2=%0d required data=%h hit=0 one read at 000", gd, gh, obs_q.size(), ed);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_addr = '0; cpu_data_in = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            l2_mem[i]   = 8'(i);
            ref_arch[i] = 8'(i);
            ref_l2[i]   = 8'(i);
        end
        test_reset();
        test_first_read();
        test_sequential();
        test_write_hit();
        test_writeback();
        test_random();
        test_back_to_back();
        test_reset_mid_alloc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion by %0t required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
